// File: rtl/avm_uart_responder.sv
// Avalon-MM UART responder: RX/TX/STATUS registers over a 2-cycle bus
// handshake, with an 8N1 transmitter and receiver on the board pins.
module avm_uart_responder #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic [31:0] avm_readdata,
    output logic        avm_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam logic [4:0]  C_ADDR_RX   = 5'h00;
    localparam logic [4:0]  C_ADDR_TX   = 5'h04;
    localparam logic [4:0]  C_ADDR_ST   = 5'h08;
    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] C_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // bus handshake
    logic        r_ack;
    logic        w_req;
    logic        w_acc;
    logic        w_rd;
    logic        w_wr;
    logic        w_rd_rx;
    logic        w_rd_st;
    logic        w_wr_tx;

    // transmit path
    tx_state_t   r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_tx_hold;
    logic        r_trdy;
    logic        r_txd;
    logic        w_tx_last;
    logic        w_tx_take;
    logic        w_tx_accept;

    // receive path
    rx_state_t   r_rx_state;
    logic [1:0]  r_rx_sync;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic [7:0]  r_rx_hold;
    logic        r_rrdy;
    logic        r_roe;
    logic        r_fe;
    logic        w_rxd;
    logic        w_rx_done;
    logic        w_stop_ok;
    logic        w_stop_bad;

    // upper write-data bits carry nothing for this peripheral
    logic        w_unused;

    assign w_unused = ^avm_writedata[31:8];

    assign w_req   = avm_read | avm_write;
    assign w_acc   = w_req & r_ack;
    assign w_rd    = w_acc & avm_read;
    assign w_wr    = w_acc & avm_write & ~avm_read;
    assign w_rd_rx = w_rd & (avm_address == C_ADDR_RX);
    assign w_rd_st = w_rd & (avm_address == C_ADDR_ST);
    assign w_wr_tx = w_wr & (avm_address == C_ADDR_TX);

    assign avm_waitrequest = w_req & ~r_ack;

    // the shifter takes the hold byte from idle, or straight out of a stop
    // bit so consecutive frames run with no gap
    assign w_tx_last = (r_tx_cnt == C_BIT_LAST);
    assign w_tx_take = ~r_trdy
                     & ((r_tx_state == TX_IDLE)
                     | ((r_tx_state == TX_STOP) & w_tx_last));

    // a write landing as the hold byte leaves is accepted: hold is free
    assign w_tx_accept = w_wr_tx & (r_trdy | w_tx_take);

    assign w_rxd      = r_rx_sync[1];
    assign w_rx_done  = (r_rx_state == RX_STOP) & (r_rx_cnt == C_BIT_LAST);
    assign w_stop_ok  = w_rx_done & w_rxd;
    assign w_stop_bad = w_rx_done & ~w_rxd;

    assign uart_txd = r_txd;

    // one wait cycle per access, accept on the following cycle
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_req & ~r_ack;
        end
    end

    // read data is captured on the accept edge
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            avm_readdata <= 32'h0;
        end else if (w_rd) begin
            case (avm_address)
                C_ADDR_RX: avm_readdata <= {24'h0, r_rx_hold};
                C_ADDR_ST: avm_readdata <= {24'h0, r_rrdy, r_trdy, 2'b00,
                                            r_roe, r_fe, 2'b00};
                default:   avm_readdata <= 32'h0;
            endcase
        end
    end

    // TX holding register and its ready flag
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_tx_hold <= 8'h0;
            r_trdy    <= 1'b1;
        end else if (w_tx_accept) begin
            r_tx_hold <= avm_writedata[7:0];
            r_trdy    <= 1'b0;
        end else if (w_tx_take) begin
            r_trdy    <= 1'b1;
        end
    end

    // TX frame sequencer: start, 8 data bits LSB first, stop
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= 16'h0;
            r_tx_bit   <= 3'h0;
            r_tx_shift <= 8'h0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_take) begin
                        r_tx_shift <= r_tx_hold;
                        r_tx_cnt   <= 16'h0;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tx_last) begin
                        r_tx_cnt   <= 16'h0;
                        r_tx_bit   <= 3'h0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'h1;
                    end
                end
                TX_DATA: begin
                    if (w_tx_last) begin
                        r_tx_cnt <= 16'h0;
                        if (r_tx_bit == 3'h7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'h1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'h1;
                    end
                end
                TX_STOP: begin
                    if (w_tx_last) begin
                        r_tx_cnt <= 16'h0;
                        if (w_tx_take) begin
                            r_tx_shift <= r_tx_hold;
                            r_txd      <= 1'b0;
                            r_tx_state <= TX_START;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 16'h1;
                    end
                end
                default: begin
                    r_txd      <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], uart_rxd};
        end
    end

    // RX frame sequencer: centre-sampled start check, data and stop bits
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= 16'h0;
            r_rx_bit   <= 3'h0;
            r_rx_shift <= 8'h0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= 16'h0;
                    if (!w_rxd) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == C_HALF_LAST) begin
                        r_rx_cnt <= 16'h0;
                        r_rx_bit <= 3'h0;
                        if (w_rxd) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'h1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == C_BIT_LAST) begin
                        r_rx_cnt   <= 16'h0;
                        r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'h7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 3'h1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'h1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == C_BIT_LAST) begin
                        r_rx_cnt   <= 16'h0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'h1;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // RX holding register and status flags; a new event beats a clear
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_rx_hold <= 8'h0;
            r_rrdy    <= 1'b0;
            r_roe     <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            if (w_stop_ok) begin
                r_rx_hold <= r_rx_shift;
            end

            if (w_stop_ok) begin
                r_rrdy <= 1'b1;
            end else if (w_rd_rx) begin
                r_rrdy <= 1'b0;
            end

            if (w_stop_ok & r_rrdy & ~w_rd_rx) begin
                r_roe <= 1'b1;
            end else if (w_rd_rx) begin
                r_roe <= 1'b0;
            end

            if (w_stop_bad) begin
                r_fe <= 1'b1;
            end else if (w_rd_st) begin
                r_fe <= 1'b0;
            end
        end
    end

endmodule
